adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and sum width in bits.
REQ-002 The block SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-005 The block SHALL have ports req0_ready / req1_ready  output  1  operands accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b / req1_a, req1_b  input  WIDTH  addends.
REQ-007 The block SHALL have ports req0_cin / req1_cin  input  1  carry-in.
REQ-008 The block SHALL have port resp_valid  output  1  result available.
REQ-009 The block SHALL have port resp_ready  input  1  consumer accepts the result.
REQ-010 The block SHALL have port resp_id  output  1  requester index the result belongs to.
REQ-011 The block SHALL have port resp_sum  output  WIDTH  sum bits.
REQ-012 The block SHALL have port resp_overflow  output  1  carry out of the MSB.
REQ-013 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement a 3-state FSM: IDLE, EXEC, RESP.
REQ-015 In IDLE, the block SHALL assert exactly one reqN_ready, for the granted requester, only while that requester's valid is high; no ready is asserted outside IDLE.
REQ-016 On the handshake (reqN_valid && reqN_ready), the block SHALL register a, b, cin and id, then move to EXEC.
REQ-017 In EXEC, the block SHALL register {overflow, sum} = a + b + cin, computed at WIDTH+1 bits from registered operands, and move to RESP.
REQ-018 In RESP, the block SHALL hold resp_valid high with resp_id/resp_sum/resp_overflow stable until resp_ready is high; it SHALL then return to IDLE on the same edge.
REQ-019 The response SHALL appear exactly 2 cycles after the handshake edge.
REQ-020 Minimum issue interval SHALL be 3 cycles.
REQ-021 resp_sum, resp_overflow and resp_id SHALL hold their last value outside RESP.
REQ-022 A requester that drops valid before being granted SHALL NOT be served; no request is queued internally.
REQ-023 If resp_ready is high on RESP entry, the result SHALL be consumed in that first RESP cycle.

Reset
REQ-024 On rst, the block SHALL go to IDLE asynchronously and clear the following to 0: resp_valid, resp_sum, resp_overflow, resp_id, busy, reqN_ready, operand registers.
REQ-025 On rst, the last-grant register SHALL be set to 1, so requester 0 wins the first contention.
REQ-026 Reset asserted in EXEC or RESP SHALL discard the in-flight result without emitting it.

Configuration
REQ-027 With ADDER_ARB_ROUND_ROBIN_EN defined, when both requesters are valid in IDLE the block SHALL grant the requester not granted last; a single valid requester SHALL always be granted.
REQ-028 Without ADDER_ARB_ROUND_ROBIN_EN, grant SHALL be fixed-priority: requester 0 always wins contention; the last-grant register SHALL be absent.

Structure
REQ-029 A shared package adder_arb_pkg SHALL hold the FSM state enum (IDLE, EXEC, RESP) and the default WIDTH constant.
REQ-030 The addition SHALL be performed by one instance of sub-module adder_16bit (a, b, carry_in -> sum, overflow), driven from the registered operands.

Verification
REQ-031 The bench SHALL cover: req0 a=2, b=4, cin=1, resp_ready=1 -> resp_valid 2 cycles later, sum=0x0007, overflow=0, id=0.
REQ-032 The bench SHALL cover: req1 a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, overflow=1, id=1.
REQ-033 The bench SHALL cover: both valid after reset, req0 a=8, b=5, cin=1 and req1 a=1, b=2, cin=0, with round-robin enabled -> id=0 sum=0x000E first, then id=1 sum=0x0003; with the macro absent and req0 held valid -> req1 never served.
REQ-034 The bench SHALL cover: a=0x5555, b=0xAAAA, cin=0 with resp_ready low for 4 cycles -> resp_valid held, sum=0xFFFF stable, busy=1, both readys low until release.
REQ-035 The bench SHALL cover: rst pulsed during EXEC -> resp_valid never rises for that operation; all outputs are 0 and the next request is granted from IDLE.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared FSM state encoding and default operand width
// for the adder_arbiter block.
package adder_arb_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : adder_arb_pkg

// File: rtl/adder_arbiter_adder.sv
// adder_16bit: combinational WIDTH-bit adder with carry-in; the carry out
// of the MSB is reported as overflow.
module adder_16bit
    import adder_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    localparam int unsigned FULL_W = WIDTH + 1;

    logic [FULL_W-1:0] full;

    // Sum at WIDTH+1 bits so the top bit is the carry out
    always_comb begin
        full     = FULL_W'(a) + FULL_W'(b) + FULL_W'(carry_in);
        sum      = full[WIDTH-1:0];
        overflow = full[WIDTH];
    end

endmodule : adder_16bit

// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one adder. A request is accepted in
// IDLE, its operands are added in EXEC and the result is held in RESP
// until the consumer takes it.
// Optional feature: define ADDER_ARB_ROUND_ROBIN_EN to alternate grants
// under contention; otherwise requester 0 has fixed priority.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_overflow,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             op_id;
    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;
    logic             grant;
    logic             take;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
    logic             last_grant;
`endif

    // Pick the requester that would be served this cycle
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready only in IDLE, only for the granted and still-valid requester
    always_comb begin
        req0_ready = !rst && (state == IDLE) && req0_valid && !grant;
        req1_ready = !rst && (state == IDLE) && req1_valid && grant;
        take       = req0_ready || req1_ready;
    end

    adder_16bit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a        (op_a),
        .b        (op_b),
        .carry_in (op_cin),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // Control FSM with registered operand capture and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            op_a          <= '0;
            op_b          <= '0;
            op_cin        <= 1'b0;
            op_id         <= 1'b0;
            resp_valid    <= 1'b0;
            resp_id       <= 1'b0;
            resp_sum      <= '0;
            resp_overflow <= 1'b0;
            busy          <= 1'b0;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            last_grant    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        op_a   <= grant ? req1_a   : req0_a;
                        op_b   <= grant ? req1_b   : req0_b;
                        op_cin <= grant ? req1_cin : req0_cin;
                        op_id  <= grant;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
                        last_grant <= grant;
`endif
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    resp_sum      <= add_sum;
                    resp_overflow <= add_ovf;
                    resp_id       <= op_id;
                    resp_valid    <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed self-checking bench for adder_arbiter.
// Build with ADDER_ARB_ROUND_ROBIN_EN defined to exercise the alternating
// grant expectations.
module tb_adder_arbiter;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic         resp_valid, resp_ready, resp_id, resp_overflow, busy;
    logic [W-1:0] resp_sum;

    int vectors;
    int miscompares;

    adder_arbiter #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req0_cin      (req0_cin),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .req1_cin      (req1_cin),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_sum      (resp_sum),
        .resp_overflow (resp_overflow),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_resp(input string tag, input logic id, input logic [W-1:0] sum, input logic ovf);
        check({tag, ".valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".id"},    32'(resp_id), 32'(id));
        check({tag, ".sum"},   32'(resp_sum), 32'(sum));
        check({tag, ".ovf"},   32'(resp_overflow), 32'(ovf));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"}, 32'(resp_valid), 32'd0);
        check({tag, ".busy"},  32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req0_valid  = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid  = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        resp_ready  = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst.valid", 32'(resp_valid), 32'd0);
        check("rst.sum",   32'(resp_sum), 32'd0);
        check("rst.ovf",   32'(resp_overflow), 32'd0);
        check("rst.id",    32'(resp_id), 32'd0);
        check("rst.busy",  32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("rst.rdy0", 32'(req0_ready), 32'd0);
        check("rst.rdy1", 32'(req1_ready), 32'd0);

        // req0: 2 + 4 + 1 = 7
        req0_valid = 1'b1; req0_a = 16'd2; req0_b = 16'd4; req0_cin = 1'b1;
        #1;
        check("t1.rdy0", 32'(req0_ready), 32'd1);
        check("t1.rdy1", 32'(req1_ready), 32'd0);
        tick();                               // handshake edge
        req0_valid = 1'b0;
        check("t1.exec.busy",  32'(busy), 32'd1);
        check("t1.exec.valid", 32'(resp_valid), 32'd0);
        tick();                               // second edge: result visible
        check_resp("t1", 1'b0, 16'h0007, 1'b0);
        check("t1.resp.busy", 32'(busy), 32'd1);
        tick();                               // consumed in first RESP cycle
        check_idle_outputs("t1.done");
        check("t1.hold.sum", 32'(resp_sum), 32'h0007);

        // req1: FFFF + FFFF + 1 = 1_FFFF
        req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'hFFFF; req1_cin = 1'b1;
        #1;
        check("t2.rdy1", 32'(req1_ready), 32'd1);
        check("t2.rdy0", 32'(req0_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        tick();
        check_resp("t2", 1'b1, 16'hFFFF, 1'b1);
        tick();
        check_idle_outputs("t2.done");
        check("t2.hold.id",  32'(resp_id), 32'd1);
        check("t2.hold.ovf", 32'(resp_overflow), 32'd1);

        // Contention right after reset: req0 8+5+1 = E, req1 1+2+0 = 3
        pulse_reset();
        req0_valid = 1'b1; req0_a = 16'd8; req0_b = 16'd5; req0_cin = 1'b1;
        req1_valid = 1'b1; req1_a = 16'd1; req1_b = 16'd2; req1_cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            check("c.rdy0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("c.rdy1", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
`else
            check("c.rdy0", 32'(req0_ready), 32'd1);
            check("c.rdy1", 32'(req1_ready), 32'd0);
`endif
            tick();
            check("c.exec.rdy0", 32'(req0_ready), 32'd0);
            check("c.exec.rdy1", 32'(req1_ready), 32'd0);
            tick();
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            if (i % 2 == 0) check_resp("c.rr", 1'b0, 16'h000E, 1'b0);
            else            check_resp("c.rr", 1'b1, 16'h0003, 1'b0);
`else
            check_resp("c.fixed", 1'b0, 16'h000E, 1'b0);
`endif
            tick();
            check("c.back.busy", 32'(busy), 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Back-pressure: 5555 + AAAA = FFFF held for 4 cycles
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h5555; req0_b = 16'hAAAA; req0_cin = 1'b0;
        tick();                               // handshake
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 16'd1; req1_b = 16'd1; req1_cin = 1'b0;
        tick();                               // RESP entered
        for (int i = 0; i < 4; i++) begin
            check_resp("bp", 1'b0, 16'hFFFF, 1'b0);
            check("bp.busy", 32'(busy), 32'd1);
            check("bp.rdy0", 32'(req0_ready), 32'd0);
            check("bp.rdy1", 32'(req1_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check("bp.last.valid", 32'(resp_valid), 32'd1);
        tick();                               // released, back to IDLE
        check_idle_outputs("bp.done");
        check("bp.hold.sum", 32'(resp_sum), 32'hFFFF);
        check("bp.rdy1", 32'(req1_ready), 32'd1);
        tick();                               // req1 handshake: 1 + 1 = 2
        req1_valid = 1'b0;
        tick();
        check_resp("bp.next", 1'b1, 16'h0002, 1'b0);
        tick();

        // Reset during EXEC discards the in-flight result
        req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd4; req0_cin = 1'b0;
        tick();                               // handshake, now in EXEC
        req0_valid = 1'b0;
        check("ar.exec.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("ar.valid", 32'(resp_valid), 32'd0);
        check("ar.sum",   32'(resp_sum), 32'd0);
        check("ar.ovf",   32'(resp_overflow), 32'd0);
        check("ar.id",    32'(resp_id), 32'd0);
        check("ar.busy",  32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar.novalid", 32'(resp_valid), 32'd0);
        end
        // Next request served normally: 10 + 20 + 1 = 31
        req1_valid = 1'b1; req1_a = 16'd10; req1_b = 16'd20; req1_cin = 1'b1;
        #1;
        check("ar.rdy1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        check_resp("ar.next", 1'b1, 16'h001F, 1'b0);
        tick();
        check_idle_outputs("ar.done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_adder_arbiter
